// File: rtl/pmod1553_phy_pkg.sv
// Shared types, default parameter values and counter sizing helper for the
// PMOD 1553 physical-layer conditioning block.
package pmod1553_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TX    = 2'd1,
        ST_GUARD = 2'd2
    } tx_state_e;

    localparam int DEF_CHANNELS      = 1;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_LEN    = 3;
    localparam int DEF_GUARD_CYCLES  = 12;
    localparam bit DEF_ECHO_SUPPRESS = 1'b1;

    // Bits needed to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/pmod1553_rx_filter.sv
// Single-bit receive conditioner: multi-flop synchroniser followed by a
// stability filter that only follows FILTER_LEN consecutive differing samples.
module pmod1553_rx_filter
    import pmod1553_phy_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   dout_reg, dout_next;
    logic                   sample;

    assign sample = sync_reg[SYNC_STAGES-1];
    assign dout   = dout_reg;

    // Any sample matching the current output restarts the run count.
    always_comb begin
        cnt_next  = '0;
        dout_next = dout_reg;
        if (sample != dout_reg) begin
            if (cnt_reg == CNT_LAST) begin
                dout_next = sample;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            cnt_reg  <= '0;
            dout_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            cnt_reg  <= cnt_next;
            dout_reg <= dout_next;
        end
    end

endmodule

// File: rtl/pmod1553_phy_if.sv
// N-channel conditioning between 1553 codecs and PMOD transceiver pins:
// filtered RX, sequenced/protected TX, loopback and echo suppression.
module pmod1553_phy_if
    import pmod1553_phy_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_LEN    = DEF_FILTER_LEN,
    parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
    parameter bit ECHO_SUPPRESS = DEF_ECHO_SUPPRESS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] rx_p_i,
    input  logic [CHANNELS-1:0] rx_n_i,
    output logic [CHANNELS-1:0] tx_p_o,
    output logic [CHANNELS-1:0] tx_n_o,
    output logic [CHANNELS-1:0] tx_inh_o,
    input  logic [CHANNELS-1:0] tx_p_i,
    input  logic [CHANNELS-1:0] tx_n_i,
    input  logic [CHANNELS-1:0] tx_en_i,
    output logic [CHANNELS-1:0] rx_p_o,
    output logic [CHANNELS-1:0] rx_n_o,
    output logic [CHANNELS-1:0] busy_o,
    input  logic                loopback_i,
    input  logic                err_clr_i,
    output logic [CHANNELS-1:0] err_o
);

    localparam int GW = cnt_width(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    // Loopback is applied one cycle after the request so a mid-frame change
    // never produces a partial-cycle glitch on the pins.
    logic loopback_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loopback_reg <= 1'b0;
        end else begin
            loopback_reg <= loopback_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            tx_state_e     state_reg, state_next;
            logic [GW-1:0] guard_reg, guard_next;
            logic          drv_p_reg, drv_p_next;
            logic          drv_n_reg, drv_n_next;
            logic          err_reg, err_next;
            logic          illegal;
            logic          filt_p, filt_n;
            logic          rx_src_p, rx_src_n;
            logic          suppress;

            always_comb begin
                state_next = state_reg;
                guard_next = guard_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (tx_en_i[gi]) state_next = ST_TX;
                    end
                    ST_TX: begin
                        if (!tx_en_i[gi]) begin
                            state_next = ST_GUARD;
                            guard_next = GUARD_LOAD;
                        end
                    end
                    ST_GUARD: begin
                        // Enable is only honoured on the final guard cycle.
                        if (guard_reg <= GW'(1)) begin
                            state_next = tx_en_i[gi] ? ST_TX : ST_IDLE;
                            guard_next = '0;
                        end else begin
                            guard_next = guard_reg - GW'(1);
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        guard_next = '0;
                    end
                endcase

                // Drive registers only carry data into a TX cycle; an illegal
                // pair collapses to idle-low and flags the channel.
                illegal    = (state_next == ST_TX) && tx_p_i[gi] && tx_n_i[gi];
                drv_p_next = (state_next == ST_TX) && tx_p_i[gi] && !tx_n_i[gi];
                drv_n_next = (state_next == ST_TX) && tx_n_i[gi] && !tx_p_i[gi];
                err_next   = illegal || (err_reg && !err_clr_i);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    guard_reg <= '0;
                    drv_p_reg <= 1'b0;
                    drv_n_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    guard_reg <= guard_next;
                    drv_p_reg <= drv_p_next;
                    drv_n_reg <= drv_n_next;
                    err_reg   <= err_next;
                end
            end

            assign tx_p_o[gi]   = drv_p_reg && (state_reg == ST_TX) && !loopback_reg;
            assign tx_n_o[gi]   = drv_n_reg && (state_reg == ST_TX) && !loopback_reg;
            assign tx_inh_o[gi] = (state_reg == ST_IDLE) || loopback_reg;
            assign busy_o[gi]   = (state_reg != ST_IDLE);
            assign err_o[gi]    = err_reg;

            assign rx_src_p = loopback_reg ? drv_p_reg : rx_p_i[gi];
            assign rx_src_n = loopback_reg ? drv_n_reg : rx_n_i[gi];

            pmod1553_rx_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN)
            ) u_filt_p (
                .clk   (clk),
                .reset (reset),
                .din   (rx_src_p),
                .dout  (filt_p)
            );

            pmod1553_rx_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN)
            ) u_filt_n (
                .clk   (clk),
                .reset (reset),
                .din   (rx_src_n),
                .dout  (filt_n)
            );

            assign suppress    = ECHO_SUPPRESS && busy_o[gi] && !loopback_reg;
            assign rx_p_o[gi]  = filt_p && !suppress;
            assign rx_n_o[gi]  = filt_n && !suppress;
        end
    endgenerate

endmodule
